// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared definitions for the fetch-stage program-counter unit
//
// Purpose: state encoding of the pc_unit sequencer, trap-vector mode codes
// and the default reset vector. Imported by pc_next_sel and pc_unit.
// Ports: none (package).

package pc_pkg;

    // Sequencer states; the encoding is visible on pc_unit.state.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Trap-vector mode field, tvec[1:0]. Any other value behaves as direct.
    localparam logic [1:0] TVEC_DIRECT   = 2'd0;
    localparam logic [1:0] TVEC_VECTORED = 2'd1;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux, trap-target computation, alignment check
//
// Purpose: purely combinational selection of the next fetch address.
//   RUN : trap > mret > redirect > sequential advance > hold
//   HALT: trap only; everything else holds the pc
//   BOOT: hold
// A misaligned mret/redirect target is rejected: the pc holds and the
// target is reported on o_misaligned / o_misaligned_addr.
//
// Ports:
//   i_state            current sequencer state
//   i_pc               current registered pc
//   i_fetch_valid      current registered fetch request flag
//   i_fetch_ready      imem accepts the current request
//   i_stall            pipeline stall, blocks sequential advance only
//   i_redirect_valid   branch/jump taken, target i_redirect_pc
//   i_trap_valid       trap taken; i_trap_is_irq, i_trap_cause, i_tvec
//   i_mret_valid       return from trap, target i_mepc
//   i_wfi_valid        WFI retired, suppresses sequential advance
//   o_pc_next          value for the pc register at the next edge
//   o_misaligned       a flush target was rejected this cycle
//   o_misaligned_addr  the rejected target

module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int INCR = 4
) (
    input  pc_state_e         i_state,
    input  logic [XLEN-1:0]   i_pc,
    input  logic              i_fetch_valid,
    input  logic              i_fetch_ready,
    input  logic              i_stall,
    input  logic              i_redirect_valid,
    input  logic [XLEN-1:0]   i_redirect_pc,
    input  logic              i_trap_valid,
    input  logic              i_trap_is_irq,
    input  logic [4:0]        i_trap_cause,
    input  logic [XLEN-1:0]   i_tvec,
    input  logic              i_mret_valid,
    input  logic [XLEN-1:0]   i_mepc,
    input  logic              i_wfi_valid,
    output logic [XLEN-1:0]   o_pc_next,
    output logic              o_misaligned,
    output logic [XLEN-1:0]   o_misaligned_addr
);

    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_trap_target;
    logic            w_vectored;
    logic [XLEN-1:0] w_flush_target;
    logic            w_advance;

    // Trap targets are word aligned by construction: the mode bits are
    // dropped from the base and the vectored offset is a multiple of 4.
    assign w_trap_base   = {i_tvec[XLEN-1:2], 2'b00};
    assign w_vectored    = (i_tvec[1:0] == TVEC_VECTORED) && i_trap_is_irq;
    assign w_trap_target = w_vectored ? (w_trap_base + (XLEN'(i_trap_cause) << 2))
                                      : w_trap_base;

    // mret outranks redirect, so its target is the one checked when both fire.
    assign w_flush_target = i_mret_valid ? i_mepc : i_redirect_pc;

    // A retiring WFI freezes the sequential stream for the cycle it enters HALT.
    assign w_advance = i_fetch_valid && i_fetch_ready && !i_stall && !i_wfi_valid;

    always_comb begin
        o_pc_next         = i_pc;
        o_misaligned      = 1'b0;
        o_misaligned_addr = '0;
        case (i_state)
            ST_RUN: begin
                if (i_trap_valid) begin
                    o_pc_next = w_trap_target;
                end else if (i_mret_valid || i_redirect_valid) begin
                    if (w_flush_target[1:0] != 2'b00) begin
                        o_misaligned      = 1'b1;
                        o_misaligned_addr = w_flush_target;
                    end else begin
                        o_pc_next = w_flush_target;
                    end
                end else if (w_advance) begin
                    // Modulo 2^XLEN: the top word wraps silently to zero.
                    o_pc_next = i_pc + XLEN'(INCR);
                end
            end
            ST_HALT: begin
                if (i_trap_valid) begin
                    o_pc_next = w_trap_target;
                end
            end
            default: begin
                o_pc_next = i_pc;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with handshake, flush and WFI sequencing
//
// Purpose: holds the registered fetch pc and the BOOT/RUN/HALT sequencer.
// Next-pc selection is delegated to pc_next_sel. All outputs are registered.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall               hold pc (sequential advance only)
//   fetch_ready         imem accepts the current pc
//   fetch_valid         pc is a valid fetch request (high only in RUN)
//   pc                  current fetch address
//   redirect_valid/_pc  branch/jump redirect
//   trap_valid, trap_is_irq, trap_cause, tvec   trap entry
//   mret_valid, mepc    return from trap
//   wfi_valid           WFI retired, enter HALT
//   irq_pending         wakes the unit from HALT
//   state               BOOT=0, RUN=1, HALT=2
//   misaligned_valid    one-cycle pulse per rejected flush target
//   misaligned_addr     rejected target, valid with the pulse

module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              INCR         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [XLEN-1:0]   pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              trap_valid,
    input  logic              trap_is_irq,
    input  logic [4:0]        trap_cause,
    input  logic [XLEN-1:0]   tvec,
    input  logic              mret_valid,
    input  logic [XLEN-1:0]   mepc,
    input  logic              wfi_valid,
    input  logic              irq_pending,
    output logic [1:0]        state,
    output logic              misaligned_valid,
    output logic [XLEN-1:0]   misaligned_addr
);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_fetch_valid;
    logic            r_misaligned_valid;
    logic [XLEN-1:0] r_misaligned_addr;

    logic [XLEN-1:0] w_pc_next;
    logic            w_misaligned;
    logic [XLEN-1:0] w_misaligned_addr;

    pc_next_sel #(
        .XLEN (XLEN),
        .INCR (INCR)
    ) u_next_sel (
        .i_state           (r_state),
        .i_pc              (r_pc),
        .i_fetch_valid     (r_fetch_valid),
        .i_fetch_ready     (fetch_ready),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_pc     (redirect_pc),
        .i_trap_valid      (trap_valid),
        .i_trap_is_irq     (trap_is_irq),
        .i_trap_cause      (trap_cause),
        .i_tvec            (tvec),
        .i_mret_valid      (mret_valid),
        .i_mepc            (mepc),
        .i_wfi_valid       (wfi_valid),
        .o_pc_next         (w_pc_next),
        .o_misaligned      (w_misaligned),
        .o_misaligned_addr (w_misaligned_addr)
    );

    // Sequencer and pc register. fetch_valid is registered alongside the
    // state so it is high exactly in the cycles spent in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= ST_BOOT;
            r_pc               <= RESET_VECTOR;
            r_fetch_valid      <= 1'b0;
            r_misaligned_valid <= 1'b0;
            r_misaligned_addr  <= '0;
        end else begin
            r_pc               <= w_pc_next;
            r_misaligned_valid <= w_misaligned;
            // The address is kept after the pulse; only a new rejection replaces it.
            if (w_misaligned) begin
                r_misaligned_addr <= w_misaligned_addr;
            end
            case (r_state)
                ST_BOOT: begin
                    r_state       <= ST_RUN;
                    r_fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (wfi_valid) begin
                        r_state       <= ST_HALT;
                        r_fetch_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // A trap wakes the core at its target; a pending
                    // interrupt alone resumes at the held pc.
                    if (trap_valid || irq_pending) begin
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state            = r_state;
    assign pc               = r_pc;
    assign fetch_valid      = r_fetch_valid;
    assign misaligned_valid = r_misaligned_valid;
    assign misaligned_addr  = r_misaligned_addr;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking scoreboard bench for pc_unit

module tb_pc_unit;

    localparam logic [31:0] RV   = 32'h8000_0000;
    localparam logic [1:0]  BOOT = 2'd0;
    localparam logic [1:0]  RUN  = 2'd1;
    localparam logic [1:0]  HALT = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic        trap_is_irq = 1'b0;
    logic [4:0]  trap_cause = '0;
    logic [31:0] tvec = '0;
    logic        mret_valid = 1'b0;
    logic [31:0] mepc = '0;
    logic        wfi_valid = 1'b0;
    logic        irq_pending = 1'b0;
    logic [1:0]  state;
    logic        misaligned_valid;
    logic [31:0] misaligned_addr;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        ready;
        logic        redir_v;
        logic [31:0] redir_pc;
        logic        trap_v;
        logic        irq;
        logic [4:0]  cause;
        logic [31:0] tvec;
        logic        mret_v;
        logic [31:0] mepc;
        logic        wfi;
        logic        irq_pend;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  st;
        logic        fv;
        logic        mv;
        logic        chk_addr;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    pc_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .pc               (pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .trap_valid       (trap_valid),
        .trap_is_irq      (trap_is_irq),
        .trap_cause       (trap_cause),
        .tvec             (tvec),
        .mret_valid       (mret_valid),
        .mepc             (mepc),
        .wfi_valid        (wfi_valid),
        .irq_pending      (irq_pending),
        .state            (state),
        .misaligned_valid (misaligned_valid),
        .misaligned_addr  (misaligned_addr)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ready = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] p, input logic [1:0] st,
                                input logic mv, input logic chk, input logic [31:0] a);
        exp_t e;
        e.pc = p;
        e.st = st;
        e.fv = (st == RUN);
        e.mv = mv;
        e.chk_addr = chk;
        e.addr = a;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        reset          = s.rst;
        stall          = s.stall;
        fetch_ready    = s.ready;
        redirect_valid = s.redir_v;
        redirect_pc    = s.redir_pc;
        trap_valid     = s.trap_v;
        trap_is_irq    = s.irq;
        trap_cause     = s.cause;
        tvec           = s.tvec;
        mret_valid     = s.mret_v;
        mepc           = s.mepc;
        wfi_valid      = s.wfi;
        irq_pending    = s.irq_pend;
    endtask

    task automatic test_reset();
        stim_t sq[$];
        exp_t  eq[$];
        stim_t s;
        exp_t  e;
        s = idle(); s.rst = 1'b1;
        sq.push_back(s); eq.push_back(ex(RV, BOOT, 1'b0, 1'b1, 32'h0));
        sq.push_back(s); eq.push_back(ex(RV, BOOT, 1'b0, 1'b1, 32'h0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({state, fetch_valid, misaligned_valid, pc} !== {e.st, e.fv, e.mv, e.pc})
                $display("FAIL reset[%0d] st/fv/mv/pc got %h %b %b %h want %h %b %b %h",
                         i, state, fetch_valid, misaligned_valid, pc, e.st, e.fv, e.mv, e.pc);
            else n_pass++;
            if (e.chk_addr) begin
                n_checks++;
                if (misaligned_addr !== e.addr)
                    $display("FAIL reset[%0d] misaligned_addr got %h want %h", i, misaligned_addr, e.addr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_boot();
        stim_t sq[$];
        exp_t  eq[$];
        exp_t  e;
        sq.push_back(idle()); eq.push_back(ex(RV,        RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(RV + 32'h4, RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(RV + 32'h8, RUN, 1'b0, 1'b0, 32'h0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({state, fetch_valid, misaligned_valid, pc} !== {e.st, e.fv, e.mv, e.pc})
                $display("FAIL boot[%0d] st/fv/mv/pc got %h %b %b %h want %h %b %b %h",
                         i, state, fetch_valid, misaligned_valid, pc, e.st, e.fv, e.mv, e.pc);
            else n_pass++;
        end
    endtask

    task automatic test_handshake();
        stim_t sq[$];
        exp_t  eq[$];
        stim_t s;
        exp_t  e;
        for (int k = 0; k < 3; k++) begin
            s = idle(); s.ready = 1'b0;
            sq.push_back(s); eq.push_back(ex(32'h8000_0008, RUN, 1'b0, 1'b0, 32'h0));
        end
        for (int k = 0; k < 2; k++) begin
            s = idle(); s.stall = 1'b1;
            sq.push_back(s); eq.push_back(ex(32'h8000_0008, RUN, 1'b0, 1'b0, 32'h0));
        end
        s = idle(); s.stall = 1'b1; s.ready = 1'b0;
        sq.push_back(s); eq.push_back(ex(32'h8000_0008, RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(32'h8000_000C, RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(32'h8000_0010, RUN, 1'b0, 1'b0, 32'h0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({state, fetch_valid, misaligned_valid, pc} !== {e.st, e.fv, e.mv, e.pc})
                $display("FAIL handshake[%0d] st/fv/mv/pc got %h %b %b %h want %h %b %b %h",
                         i, state, fetch_valid, misaligned_valid, pc, e.st, e.fv, e.mv, e.pc);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        stim_t sq[$];
        exp_t  eq[$];
        stim_t s;
        exp_t  e;
        s = idle();
        s.redir_v = 1'b1; s.redir_pc = 32'h8000_0100;
        s.mret_v = 1'b1;  s.mepc = 32'h8000_0200;
        s.trap_v = 1'b1;  s.tvec = 32'h8000_1001; s.irq = 1'b1; s.cause = 5'd7;
        sq.push_back(s); eq.push_back(ex(32'h8000_101C, RUN, 1'b0, 1'b0, 32'h0));
        s.irq = 1'b0; s.stall = 1'b1; s.ready = 1'b0;
        sq.push_back(s); eq.push_back(ex(32'h8000_1000, RUN, 1'b0, 1'b0, 32'h0));
        s = idle(); s.stall = 1'b1;
        s.mret_v = 1'b1; s.mepc = 32'h8000_0200;
        s.redir_v = 1'b1; s.redir_pc = 32'h8000_0100;
        sq.push_back(s); eq.push_back(ex(32'h8000_0200, RUN, 1'b0, 1'b0, 32'h0));
        s = idle(); s.ready = 1'b0; s.redir_v = 1'b1; s.redir_pc = 32'h8000_0100;
        sq.push_back(s); eq.push_back(ex(32'h8000_0100, RUN, 1'b0, 1'b0, 32'h0));
        s = idle(); s.trap_v = 1'b1; s.tvec = 32'h8000_1003; s.irq = 1'b1; s.cause = 5'd7;
        sq.push_back(s); eq.push_back(ex(32'h8000_1000, RUN, 1'b0, 1'b0, 32'h0));
        s = idle(); s.trap_v = 1'b1; s.tvec = 32'h8000_2002; s.irq = 1'b1; s.cause = 5'd5;
        sq.push_back(s); eq.push_back(ex(32'h8000_2000, RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(32'h8000_2004, RUN, 1'b0, 1'b0, 32'h0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({state, fetch_valid, misaligned_valid, pc} !== {e.st, e.fv, e.mv, e.pc})
                $display("FAIL priority[%0d] st/fv/mv/pc got %h %b %b %h want %h %b %b %h",
                         i, state, fetch_valid, misaligned_valid, pc, e.st, e.fv, e.mv, e.pc);
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        stim_t sq[$];
        exp_t  eq[$];
        stim_t s;
        exp_t  e;
        s = idle(); s.redir_v = 1'b1; s.redir_pc = 32'h8000_0102;
        sq.push_back(s); eq.push_back(ex(32'h8000_2004, RUN, 1'b1, 1'b1, 32'h8000_0102));
        sq.push_back(idle()); eq.push_back(ex(32'h8000_2008, RUN, 1'b0, 1'b0, 32'h0));
        s = idle(); s.mret_v = 1'b1; s.mepc = 32'h8000_0301;
        s.redir_v = 1'b1; s.redir_pc = 32'h8000_0400;
        sq.push_back(s); eq.push_back(ex(32'h8000_2008, RUN, 1'b1, 1'b1, 32'h8000_0301));
        sq.push_back(idle()); eq.push_back(ex(32'h8000_200C, RUN, 1'b0, 1'b1, 32'h8000_0301));
        s = idle(); s.redir_v = 1'b1; s.redir_pc = 32'hFFFF_FFFC;
        sq.push_back(s); eq.push_back(ex(32'hFFFF_FFFC, RUN, 1'b0, 1'b0, 32'h0));
        s = idle(); s.stall = 1'b1;
        sq.push_back(s); eq.push_back(ex(32'hFFFF_FFFC, RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(32'h0000_0000, RUN, 1'b0, 1'b0, 32'h0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({state, fetch_valid, misaligned_valid, pc} !== {e.st, e.fv, e.mv, e.pc})
                $display("FAIL misaligned[%0d] st/fv/mv/pc got %h %b %b %h want %h %b %b %h",
                         i, state, fetch_valid, misaligned_valid, pc, e.st, e.fv, e.mv, e.pc);
            else n_pass++;
            if (e.chk_addr) begin
                n_checks++;
                if (misaligned_addr !== e.addr)
                    $display("FAIL misaligned[%0d] misaligned_addr got %h want %h", i, misaligned_addr, e.addr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wfi();
        stim_t sq[$];
        exp_t  eq[$];
        stim_t s;
        exp_t  e;
        s = idle(); s.wfi = 1'b1;
        sq.push_back(s); eq.push_back(ex(32'h0, HALT, 1'b0, 1'b0, 32'h0));
        s = idle(); s.redir_v = 1'b1; s.redir_pc = 32'h0000_0102;
        sq.push_back(s); eq.push_back(ex(32'h0, HALT, 1'b0, 1'b0, 32'h0));
        s = idle(); s.mret_v = 1'b1; s.mepc = 32'h0000_0200;
        sq.push_back(s); eq.push_back(ex(32'h0, HALT, 1'b0, 1'b0, 32'h0));
        s = idle(); s.wfi = 1'b1;
        sq.push_back(s); eq.push_back(ex(32'h0, HALT, 1'b0, 1'b0, 32'h0));
        s = idle(); s.irq_pend = 1'b1;
        sq.push_back(s); eq.push_back(ex(32'h0, RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(32'h4, RUN, 1'b0, 1'b0, 32'h0));
        s = idle(); s.wfi = 1'b1; s.redir_v = 1'b1; s.redir_pc = 32'h8000_0040;
        sq.push_back(s); eq.push_back(ex(32'h8000_0040, HALT, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(32'h8000_0040, HALT, 1'b0, 1'b0, 32'h0));
        s = idle(); s.trap_v = 1'b1; s.tvec = 32'h8000_1001; s.irq = 1'b1; s.cause = 5'd3;
        sq.push_back(s); eq.push_back(ex(32'h8000_100C, RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(32'h8000_1010, RUN, 1'b0, 1'b0, 32'h0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({state, fetch_valid, misaligned_valid, pc} !== {e.st, e.fv, e.mv, e.pc})
                $display("FAIL wfi[%0d] st/fv/mv/pc got %h %b %b %h want %h %b %b %h",
                         i, state, fetch_valid, misaligned_valid, pc, e.st, e.fv, e.mv, e.pc);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        stim_t sq[$];
        exp_t  eq[$];
        stim_t s;
        exp_t  e;
        s = idle(); s.wfi = 1'b1;
        sq.push_back(s); eq.push_back(ex(32'h8000_1010, HALT, 1'b0, 1'b0, 32'h0));
        s = idle(); s.rst = 1'b1; s.irq_pend = 1'b1; s.trap_v = 1'b1; s.tvec = 32'h8000_3000;
        sq.push_back(s); eq.push_back(ex(RV, BOOT, 1'b0, 1'b1, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(RV, RUN, 1'b0, 1'b0, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(RV + 32'h4, RUN, 1'b0, 1'b0, 32'h0));
        s = idle(); s.ready = 1'b0; s.stall = 1'b1;
        sq.push_back(s); eq.push_back(ex(RV + 32'h4, RUN, 1'b0, 1'b0, 32'h0));
        s.rst = 1'b1; s.redir_v = 1'b1; s.redir_pc = 32'h8000_0102;
        sq.push_back(s); eq.push_back(ex(RV, BOOT, 1'b0, 1'b1, 32'h0));
        sq.push_back(idle()); eq.push_back(ex(RV, RUN, 1'b0, 1'b1, 32'h0));
        for (int i = 0; i < sq.size(); i++) begin
            drive(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if ({state, fetch_valid, misaligned_valid, pc} !== {e.st, e.fv, e.mv, e.pc})
                $display("FAIL reset_mid[%0d] st/fv/mv/pc got %h %b %b %h want %h %b %b %h",
                         i, state, fetch_valid, misaligned_valid, pc, e.st, e.fv, e.mv, e.pc);
            else n_pass++;
            if (e.chk_addr) begin
                n_checks++;
                if (misaligned_addr !== e.addr)
                    $display("FAIL reset_mid[%0d] misaligned_addr got %h want %h", i, misaligned_addr, e.addr);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_handshake();
        test_priority();
        test_misaligned();
        test_wfi();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
